uart_mmio: RTL and testbench
============================

// Module: uart_mmio
// PURPOSE
//  Memory-mapped 8N1 UART peripheral; responder (slave) side of the mem_mux data-bus port.
//  Sits on one mem_mux slave slot, e.g. MATCH_ADDR 32'h13000000 / MASK 32'hff000000.
//  The core writes bytes into a TX FIFO and polls/consumes received bytes through four 32-bit registers.
// PARAMETERS
//  MEMORY_TYPE    1    1 = RData registered (BSRAM-style timing), 0 = RData combinational
//  TX_FIFO_DEPTH  8    TX FIFO entries; power of two, 2..64
//  BAUD_DIV_RST   117  reset divider in clk cycles per bit (13.5 MHz / 115200)
// PORTS
//  clk      in   1   bus/peripheral clock (clk_dmem domain)
//  rst_n    in   1   asynchronous active-low reset
//  Write    in   4   byte write strobes; all 0 = no write
//  Addr     in   32  byte address; only Addr[3:2] decoded
//  WData    in   32  write data
//  RData    out  32  read data
//  uart_tx  out  1   serial out, idle high
//  uart_rx  in   1   serial in, asynchronous, idle high
// BEHAVIOUR
//  Register map (Addr[3:2]):
//   0 TXDATA  W: Write[0] pushes WData[7:0]. R: 0.
//   1 RXDATA  R: {23'd0, rx_valid, rx_byte}. W: Write[0] clears rx_valid (pop).
//   2 STATUS  R: {26'd0, frm_err, rx_ovr, tx_ovf, tx_busy, tx_full, tx_empty}.
//             W: Write[0] with WData bit=1 clears sticky bits [5:3] (W1C).
//   3 BAUDDIV RW: [15:0] divider; Write[0] and Write[1] update the low and high bytes. Values <4 read back as written, used as 4.
//  No read side effects: the bus has no read strobe.
//  Read timing:
//   MEMORY_TYPE=1: RData updated at posedge from the current Addr (1-cycle latency).
//   MEMORY_TYPE=0: RData is a combinational function of Addr.
//  Reset values: RData=0, uart_tx=1, FIFO empty, rx_valid=0, all sticky bits 0, BAUDDIV=BAUD_DIV_RST.
//  TX FIFO
//   - Push when full and no pop in the same cycle: byte dropped, tx_ovf<=1.
//   - Push when full with a pop in the same cycle: push accepted.
//   - Pointers wrap modulo TX_FIFO_DEPTH, with one extra bit for full/empty.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//   - Pops the FIFO in IDLE when it is non-empty.
//   - Each bit lasts exactly div clk cycles; div is latched at START.
//   - Back-to-back frames with no idle gap.
//   - tx_busy = (state != IDLE).
//   - First start-bit edge appears 1 cycle after the push (FIFO was empty, TX idle).
//  RX input: 2-flop synchronizer on uart_rx.
//  RX FSM: IDLE -> START -> DATA -> STOP.
//   - IDLE: waits for a falling edge.
//   - START: re-checks low at div/2; if high (glitch) -> IDLE.
//   - DATA: samples 8 bits at div intervals from mid-bit.
//   - STOP: samples the stop bit.
//   - Stop bit 0: frm_err<=1 and the byte is still delivered.
//  RX delivery
//   - rx_valid=0: rx_byte<=byte, rx_valid<=1.
//   - rx_valid=1: byte discarded, old byte kept, rx_ovr<=1.
//   - CPU pop and delivery in the same cycle: the new byte is stored with rx_valid=1 and no overrun.
//  BAUDDIV writes mid-frame do not affect the frame in flight.
//  Reset asserted mid-frame: uart_tx forced to 1 immediately; a partial RX byte is discarded.
// STRUCTURE
//  uart_pkg: register offsets (REG_TXDATA..REG_BAUDDIV), STATUS bit indices,
//   typedef enum {IDLE,START,DATA,STOP} uart_state_t, MIN_DIV=4.
//  Sub-module uart_tx_fifo (DEPTH, 8-bit): push/pop/full/empty/count.
//  TX FSM, RX FSM, register file and read mux live in uart_mmio.
// TESTING
//  1. Reset, read STATUS -> 32'h00000001; BAUDDIV reads 117; uart_tx=1.
//  2. BAUDDIV=16, write TXDATA 8'hA5 -> uart_tx waveform 0,1,0,1,0,0,1,0,1,1, 16 clk/bit; tx_busy during the frame.
//  3. Push 9 bytes back-to-back (depth 8, TX idle):
//     - the first is popped next cycle, so all 9 are accepted and tx_ovf=0;
//     - a 10th push while full -> tx_ovf=1; write STATUS 32'h08 -> tx_ovf=0.
//  4. Drive RX frame 8'h3C at div=16 -> RXDATA reads 32'h13C.
//     Second frame 8'h55 before pop -> RXDATA still 32'h13C, rx_ovr=1.
//  5. RX frame with stop bit 0 -> frm_err=1 and byte delivered.
//     A 3-cycle low glitch on uart_rx -> no byte.
//  6. Assert rst_n low mid-TX-frame -> uart_tx=1 same cycle, FIFO empty.
//     Repeat tests 2 and 4 with MEMORY_TYPE=0 and check combinational RData.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and state encoding shared by the UART peripheral.
package uart_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_FRM_ERR  = 5;
  localparam logic [15:0] MIN_DIV = 16'd4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with an extra pointer bit for full/empty; a push while full succeeds only alongside a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count   = wp - rp;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a TX FIFO, single-byte RX holding register and programmable divider.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int MEMORY_TYPE   = 1,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int BAUD_DIV_RST  = 117
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Write,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        uart_tx,
  input  logic        uart_rx
);
  logic [1:0] sel;
  logic tx_push, rx_pop, st_wr;
  logic [15:0] baud_div;
  logic tx_ovf, rx_ovr, frm_err, rx_valid;
  logic [7:0] rx_byte;
  logic fifo_full, fifo_empty, tx_pop;
  logic [7:0] fifo_dout;
  logic [$clog2(TX_FIFO_DEPTH):0] fifo_count;
  logic [31:0] rd;
  logic unused;
  assign unused  = ^{Addr[31:4], Addr[1:0], WData[31:16], Write[3:2]};
  assign sel     = Addr[3:2];
  assign tx_push = Write[0] && sel == REG_TXDATA;
  assign rx_pop  = Write[0] && sel == REG_RXDATA;
  assign st_wr   = Write[0] && sel == REG_STATUS;

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(WData[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );

  uart_state_t tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0] tx_sh;
  logic [2:0] tx_bit;
  // Popping at the end of STOP lets the next frame follow with no idle gap.
  assign tx_pop = (fifo_count != '0) && (tx_state == IDLE || (tx_state == STOP && tx_cnt == '0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= MIN_DIV;
      tx_sh    <= '0;
      tx_bit   <= '0;
    end else if (tx_pop) begin
      tx_state <= START;
      uart_tx  <= 1'b0;
      tx_div   <= eff_div(baud_div);
      tx_cnt   <= eff_div(baud_div) - 16'd1;
      tx_sh    <= fifo_dout;
    end else if (tx_state != IDLE) begin
      if (tx_cnt != '0) tx_cnt <= tx_cnt - 16'd1;
      else begin
        tx_cnt <= tx_div - 16'd1;
        if (tx_state == START) begin
          tx_state <= DATA;
          uart_tx  <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_bit   <= '0;
        end else if (tx_state == DATA && tx_bit == 3'd7) begin
          tx_state <= STOP;
          uart_tx  <= 1'b1;
        end else if (tx_state == DATA) begin
          uart_tx <= tx_sh[0];
          tx_sh   <= tx_sh >> 1;
          tx_bit  <= tx_bit + 3'd1;
        end else tx_state <= IDLE;
      end
    end

  uart_state_t rx_state;
  logic rx_s1, rx_s2, rx_d, rx_done, rx_stop;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0] rx_sh;
  logic [2:0] rx_bit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= MIN_DIV;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_done  <= 1'b0;
      rx_stop  <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      rx_done <= 1'b0;
      if (rx_state == IDLE) begin
        if (rx_d && !rx_s2) begin
          rx_state <= START;
          rx_div   <= eff_div(baud_div);
          rx_cnt   <= (eff_div(baud_div) >> 1) - 16'd1;
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 16'd1;
      else begin
        rx_cnt <= rx_div - 16'd1;
        if (rx_state == START) begin
          rx_state <= rx_s2 ? IDLE : DATA;
          rx_bit   <= '0;
        end else if (rx_state == DATA) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= STOP;
        end else begin
          rx_state <= IDLE;
          rx_done  <= 1'b1;
          rx_stop  <= rx_s2;
        end
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      baud_div <= 16'(BAUD_DIV_RST);
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (Write[0] && sel == REG_BAUDDIV) baud_div[7:0] <= WData[7:0];
      if (Write[1] && sel == REG_BAUDDIV) baud_div[15:8] <= WData[15:8];
      if (st_wr) begin
        tx_ovf  <= tx_ovf & ~WData[ST_TX_OVF];
        rx_ovr  <= rx_ovr & ~WData[ST_RX_OVR];
        frm_err <= frm_err & ~WData[ST_FRM_ERR];
      end
      if (tx_push && fifo_full && !tx_pop) tx_ovf <= 1'b1;
      if (rx_done && !rx_stop) frm_err <= 1'b1;
      if (rx_done && (!rx_valid || rx_pop)) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rx_done) rx_ovr <= 1'b1;
      else if (rx_pop) rx_valid <= 1'b0;
    end

  assign rd = sel == REG_TXDATA ? 32'd0 :
              sel == REG_RXDATA ? {23'd0, rx_valid, rx_byte} :
              sel == REG_STATUS ? {26'd0, frm_err, rx_ovr, tx_ovf, tx_state != IDLE, fifo_full, fifo_empty} :
              {16'd0, baud_div};

  generate
    if (MEMORY_TYPE != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) RData <= '0;
        else RData <= rd;
    end else begin : g_comb
      assign RData = rd;
    end
  endgenerate
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench driving a registered-read and a combinational-read instance in lockstep.
module tb_uart_mmio;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] wr = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic rx = 1'b1;
  logic [31:0] rdata1, rdata0;
  logic tx1, tx0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_mmio #(.MEMORY_TYPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .Write(wr), .Addr(addr), .WData(wdata),
    .RData(rdata1), .uart_tx(tx1), .uart_rx(rx)
  );
  uart_mmio #(.MEMORY_TYPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Write(wr), .Addr(addr), .WData(wdata),
    .RData(rdata0), .uart_tx(tx0), .uart_rx(rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s = 4'h1);
    addr = {28'h1300000, r, 2'b00};
    wdata = d;
    wr = s;
    cyc();
    wr = '0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
    addr = {28'h1300000, r, 2'b00};
    wr = '0;
    #1 check({tag, "_comb"}, rdata0, exp);
    cyc();
    check({tag, "_reg"}, rdata1, exp);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] e;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
    read_check(tag, REG_RXDATA, e);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cyc(div);
    end
    rx = 1'b1;
  endtask

  // Decodes frames on the registered instance's line at mid-bit (div 16) against the TX scoreboard.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      cyc();
      if (mon_en && tx1 === 1'b0) begin
        cyc(8);
        check("tx_start_mid", tx1, 1'b0);
        for (int i = 0; i < 8; i++) begin
          cyc(16);
          b[i] = tx1;
        end
        cyc(16);
        check("tx_stop", tx1, 1'b1);
        check("tx_frame_expected", tx_q.size() != 0, 1'b1);
        if (tx_q.size() != 0) check("tx_byte", b, tx_q.pop_front());
      end
    end
  end

  initial begin
    logic [9:0] wave;
    int n;
    cyc(3);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_tx", {tx0, tx1}, 2'b11);
    rst_n = 1'b1;
    cyc();
    read_check("t1_status", REG_STATUS, 32'h1);
    read_check("t1_baud", REG_BAUDDIV, 32'd117);
    check("t1_tx", {tx0, tx1}, 2'b11);

    bus_write(REG_BAUDDIV, 32'h1234, 4'h3);
    read_check("baud_both", REG_BAUDDIV, 32'h1234);
    bus_write(REG_BAUDDIV, 32'hFF02, 4'h1);
    read_check("baud_lo", REG_BAUDDIV, 32'h1202);
    bus_write(REG_BAUDDIV, 32'h2, 4'h3);
    read_check("baud_small", REG_BAUDDIV, 32'h2);
    bus_write(REG_BAUDDIV, 32'd16, 4'h3);
    read_check("baud_16", REG_BAUDDIV, 32'd16);

    wave = 10'b1101001010;
    bus_write(REG_TXDATA, 32'hA5);
    addr = {28'h1300000, REG_STATUS, 2'b00};
    check("t2_pre", tx1, 1'b1);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 16; c++) begin
        cyc();
        check($sformatf("t2_bit%0d_c%0d", b, c), {tx0, tx1}, {2{wave[b]}});
        if (c == 0) check($sformatf("t2_busy%0d", b), rdata0[ST_TX_BUSY], 1'b1);
      end
    cyc();
    check("t2_idle_tx", tx1, 1'b1);
    read_check("t2_idle", REG_STATUS, 32'h1);

    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tx_q.push_back(8'(i * 37 + 3));
      bus_write(REG_TXDATA, 32'(i * 37 + 3));
    end
    read_check("t3_full", REG_STATUS, 32'h6);
    bus_write(REG_TXDATA, 32'hEE);
    read_check("t3_ovf", REG_STATUS, 32'hE);
    bus_write(REG_STATUS, 32'h08);
    read_check("t3_ovf_clr", REG_STATUS, 32'h6);
    n = 0;
    while (tx_q.size() != 0 && n < 3000) begin
      cyc();
      n++;
    end
    check("t3_drain", tx_q.size(), 0);
    cyc(20);
    mon_en = 1'b0;
    read_check("t3_idle", REG_STATUS, 32'h1);

    rx_q.push_back(32'h13C);
    drive_rx(8'h3C, 1'b1, 16);
    cyc(4);
    read_rx("t4_rx1");
    rx_q.push_back(32'h13C);
    drive_rx(8'h55, 1'b1, 16);
    cyc(4);
    read_rx("t4_keep");
    read_check("t4_ovr", REG_STATUS, 32'h11);
    bus_write(REG_RXDATA, 32'h1);
    read_check("t4_pop", REG_RXDATA, 32'h3C);
    bus_write(REG_STATUS, 32'h10);
    read_check("t4_clr", REG_STATUS, 32'h1);

    rx_q.push_back(32'h1C3);
    drive_rx(8'hC3, 1'b0, 16);
    cyc(4);
    read_rx("t5_frm_byte");
    read_check("t5_frm", REG_STATUS, 32'h21);
    bus_write(REG_RXDATA, 32'h1);
    bus_write(REG_STATUS, 32'h20);
    read_check("t5_clr", REG_STATUS, 32'h1);
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(40);
    read_check("t5_glitch", REG_RXDATA, 32'h0C3);
    read_check("t5_glitch_st", REG_STATUS, 32'h1);

    bus_write(REG_TXDATA, 32'h00);
    bus_write(REG_TXDATA, 32'hFF);
    cyc(40);
    check("t6_mid", {tx0, tx1}, 2'b00);
    addr = {28'h1300000, REG_STATUS, 2'b00};
    rst_n = 1'b0;
    #1 check("t6_tx_async", {tx0, tx1}, 2'b11);
    check("t6_fifo_empty", rdata0, 32'h1);
    check("t6_rdata_rst", rdata1, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc();
    read_check("t6_baud", REG_BAUDDIV, 32'd117);
    read_check("t6_status", REG_STATUS, 32'h1);
    check("t6_tx_idle", {tx0, tx1}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
